cache_miss_controller: RTL and testbench

Controller sitting between the processor-side request port and the two-level hierarchy: looks up the fully associative L1 cache, handles write-back of dirty victims to RAM, refills the cache on misses, and returns one response per request. Policy is write-back, write-allocate. The cache stores data and selects the victim; RAM is a handshaked, variable-latency slave. This block owns all sequencing between them.

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/event_counter.sv | 22 ++
 rtl/cache_miss_controller.sv | 202 ++++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the L1 miss controller.
package cache_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_FILL,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [DEF_ADDR_W-1:0] tag;
        logic [DEF_DATA_W-1:0] data;
    } victim_t;

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter with asynchronous active-high reset.
module event_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (inc_i)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences lookup, dirty-victim write-back, refill and response for a
// write-back/write-allocate fully associative L1 in front of a handshaked RAM.
module cache_miss_controller
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_hit_o,
    output logic              cache_lookup_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    input  logic              cache_hit_i,
    input  logic [DATA_W-1:0] cache_rdata_i,
    input  logic              cache_victim_valid_i,
    input  logic              cache_victim_dirty_i,
    input  logic [ADDR_W-1:0] cache_victim_tag_i,
    input  logic [DATA_W-1:0] cache_victim_data_i,
    output logic              cache_fill_o,
    output logic [DATA_W-1:0] cache_fill_data_o,
    output logic              cache_fill_dirty_o,
    output logic              ram_req_o,
    output logic              ram_write_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_ack_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o
);

    state_e              state_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_hit_q;
    logic                cache_lookup_q;
    logic [ADDR_W-1:0]   cache_addr_q;
    logic                cache_fill_q;
    logic [DATA_W-1:0]   cache_fill_data_q;
    logic                cache_fill_dirty_q;
    logic                ram_req_q;
    logic                ram_write_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    victim_t             victim;
    logic                hit_inc;
    logic                miss_inc;

    assign victim = '{valid: cache_victim_valid_i,
                      dirty: cache_victim_dirty_i,
                      tag:   DEF_ADDR_W'(cache_victim_tag_i),
                      data:  DEF_DATA_W'(cache_victim_data_i)};

    assign hit_inc  = (state_q == ST_LOOKUP) &&  cache_hit_i;
    assign miss_inc = (state_q == ST_LOOKUP) && !cache_hit_i;

    // Strobes default low each cycle; every output is set on the transition into its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            write_q            <= 1'b0;
            addr_q             <= '0;
            wdata_q            <= '0;
            req_ready_q        <= 1'b1;
            resp_valid_q       <= 1'b0;
            resp_data_q        <= '0;
            resp_hit_q         <= 1'b0;
            cache_lookup_q     <= 1'b0;
            cache_addr_q       <= '0;
            cache_fill_q       <= 1'b0;
            cache_fill_data_q  <= '0;
            cache_fill_dirty_q <= 1'b0;
            ram_req_q          <= 1'b0;
            ram_write_q        <= 1'b0;
            ram_addr_q         <= '0;
            ram_wdata_q        <= '0;
        end else begin
            cache_lookup_q <= 1'b0;
            cache_fill_q   <= 1'b0;
            resp_valid_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_q        <= req_write_i;
                        addr_q         <= req_addr_i;
                        wdata_q        <= req_data_i;
                        req_ready_q    <= 1'b0;
                        cache_lookup_q <= 1'b1;
                        cache_addr_q   <= req_addr_i;
                        state_q        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    resp_hit_q <= cache_hit_i;
                    if (cache_hit_i && !write_q) begin
                        resp_data_q  <= cache_rdata_i;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (!cache_hit_i && victim.valid && victim.dirty) begin
                        ram_req_q   <= 1'b1;
                        ram_write_q <= 1'b1;
                        ram_addr_q  <= ADDR_W'(victim.tag);
                        ram_wdata_q <= DATA_W'(victim.data);
                        state_q     <= ST_WRITEBACK;
                    end else if (write_q) begin
                        cache_fill_q       <= 1'b1;
                        cache_fill_data_q  <= wdata_q;
                        cache_fill_dirty_q <= 1'b1;
                        state_q            <= ST_FILL;
                    end else begin
                        ram_req_q   <= 1'b1;
                        ram_write_q <= 1'b0;
                        ram_addr_q  <= addr_q;
                        state_q     <= ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (ram_ack_i) begin
                        if (write_q) begin
                            ram_req_q          <= 1'b0;
                            ram_write_q        <= 1'b0;
                            cache_fill_q       <= 1'b1;
                            cache_fill_data_q  <= wdata_q;
                            cache_fill_dirty_q <= 1'b1;
                            state_q            <= ST_FILL;
                        end else begin
                            ram_write_q <= 1'b0;
                            ram_addr_q  <= addr_q;
                            state_q     <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (ram_ack_i) begin
                        ram_req_q          <= 1'b0;
                        cache_fill_q       <= 1'b1;
                        cache_fill_data_q  <= ram_rdata_i;
                        cache_fill_dirty_q <= 1'b0;
                        state_q            <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Fill data is the refilled word for reads and the write data for writes.
                    resp_data_q  <= cache_fill_data_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    ram_req_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    event_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (hit_inc),
        .cnt_o (hit_count_o)
    );

    event_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (miss_inc),
        .cnt_o (miss_count_o)
    );

    assign req_ready_o        = req_ready_q;
    assign resp_valid_o       = resp_valid_q;
    assign resp_data_o        = resp_data_q;
    assign resp_hit_o         = resp_hit_q;
    assign cache_lookup_o     = cache_lookup_q;
    assign cache_addr_o       = cache_addr_q;
    assign cache_fill_o       = cache_fill_q;
    assign cache_fill_data_o  = cache_fill_data_q;
    assign cache_fill_dirty_o = cache_fill_dirty_q;
    assign ram_req_o          = ram_req_q;
    assign ram_write_o        = ram_write_q;
    assign ram_addr_o         = ram_addr_q;
    assign ram_wdata_o        = ram_wdata_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: behavioural cache and RAM models, response scoreboard.
module tb_cache_miss_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = '0, req_data = '0;
    logic       req_ready_o, resp_valid_o, resp_hit_o;
    logic [7:0] resp_data_o;
    logic       cache_lookup_o, cache_fill_o, cache_fill_dirty_o;
    logic [7:0] cache_addr_o, cache_fill_data_o;
    logic       cache_hit;
    logic [7:0] cache_rdata;
    logic       vic_valid = 1'b0, vic_dirty = 1'b0;
    logic [7:0] vic_tag = '0, vic_data = '0;
    logic       ram_req_o, ram_write_o, ram_ack;
    logic [7:0] ram_addr_o, ram_wdata_o, ram_rdata;
    logic [7:0] hit_count_o, miss_count_o;

    cache_miss_controller dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_hit_o(resp_hit_o),
        .cache_lookup_o(cache_lookup_o), .cache_addr_o(cache_addr_o),
        .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
        .cache_victim_valid_i(vic_valid), .cache_victim_dirty_i(vic_dirty),
        .cache_victim_tag_i(vic_tag), .cache_victim_data_i(vic_data),
        .cache_fill_o(cache_fill_o), .cache_fill_data_o(cache_fill_data_o),
        .cache_fill_dirty_o(cache_fill_dirty_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_ack_i(ram_ack), .ram_rdata_i(ram_rdata),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: 8 entries, combinational lookup, fill updates a match or installs into vic_slot.
    logic [7:0] c_tag [8];
    logic [7:0] c_data[8];
    logic       c_val [8];
    int         vic_slot = 2;
    int         fill_cnt = 0;
    logic [7:0] last_fill_data = '0;
    logic       last_fill_dirty = 1'b0;

    always_comb begin
        cache_hit   = 1'b0;
        cache_rdata = '0;
        for (int i = 0; i < 8; i++)
            if (cache_lookup_o && c_val[i] && c_tag[i] == cache_addr_o) begin
                cache_hit   = 1'b1;
                cache_rdata = c_data[i];
            end
    end

    always @(posedge clk) begin
        if (!rst && cache_fill_o) begin
            int slot;
            slot = vic_slot;
            for (int i = 0; i < 8; i++)
                if (c_val[i] && c_tag[i] == cache_addr_o) slot = i;
            c_val[slot]  <= 1'b1;
            c_tag[slot]  <= cache_addr_o;
            c_data[slot] <= cache_fill_data_o;
            fill_cnt        <= fill_cnt + 1;
            last_fill_data  <= cache_fill_data_o;
            last_fill_dirty <= cache_fill_dirty_o;
        end
    end

    // RAM model: acks after ram_lat wait cycles of a continuous request.
    logic [7:0] mem[256];
    int ram_lat = 0, wcnt = 0;
    int rd_cnt = 0, wr_cnt = 0, req_cyc = 0;
    logic [7:0] last_wr_addr = '0, last_wr_data = '0;

    assign ram_ack   = ram_req_o && (wcnt == ram_lat);
    assign ram_rdata = mem[ram_addr_o];

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (ram_req_o) wcnt <= ram_ack ? 0 : wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (!rst && ram_req_o) begin
            req_cyc <= req_cyc + 1;
            if (ram_ack) begin
                if (ram_write_o) begin
                    wr_cnt            <= wr_cnt + 1;
                    last_wr_addr      <= ram_addr_o;
                    last_wr_data      <= ram_wdata_o;
                    mem[ram_addr_o]   <= ram_wdata_o;
                end else
                    rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Scoreboard: expected responses pushed at accept, popped on resp_valid.
    typedef struct {
        logic [7:0] data;
        logic       hit;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    int resp_seen = 0, acc_cnt = 0;

    always @(negedge clk) begin
        if (!rst && resp_valid_o) begin
            resp_seen++;
            if (sbq.size() == 0)
                check("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                check("resp_data", 32'(resp_data_o), 32'(e.data));
                check("resp_hit", 32'(resp_hit_o), 32'(e.hit));
                check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    always @(posedge clk) if (!rst && req_valid && req_ready_o) acc_cnt <= acc_cnt + 1;

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic hold, output int acc);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr, wdata;
        logic       vv, vd;
        logic [7:0] vtag, vdata;
        int         slot, lat;
        logic [7:0] exp_data;
        logic       exp_hit;
        int         exp_lat, exp_rd, exp_wr, exp_req;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int acc, exp_hits, exp_miss, rd0, wr0, rq0, f0, r0, a0;
        vec_t v;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h64] = 8'h05;
        mem[8'h70] = 8'h5A;
        mem[8'h80] = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            c_val[i] = 1'b0; c_tag[i] = '0; c_data[i] = '0;
        end
        c_val[0] = 1'b1; c_tag[0] = 8'h04; c_data[0] = 8'h05;
        c_val[1] = 1'b1; c_tag[1] = 8'h05; c_data[1] = 8'h03;

        //           wr    addr   wdata  vv    vd    vtag   vdata  slot lat data   hit   lat rd wr req
        vecs[0] = '{1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2, 0, 8'h05, 1'b1, 2, 0, 0, 0};
        vecs[1] = '{1'b0, 8'h64, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 2, 3, 8'h05, 1'b0, 7, 1, 0, 4};
        vecs[2] = '{1'b1, 8'h66, 8'hAA, 1'b1, 1'b1, 8'h65, 8'h03, 3, 1, 8'hAA, 1'b0, 5, 0, 1, 2};
        vecs[3] = '{1'b0, 8'h70, 8'h00, 1'b1, 1'b0, 8'h11, 8'h00, 4, 0, 8'h5A, 1'b0, 4, 1, 0, 1};
        vecs[4] = '{1'b1, 8'h04, 8'h77, 1'b1, 1'b1, 8'h99, 8'h22, 5, 0, 8'h77, 1'b1, 3, 0, 0, 0};
        vecs[5] = '{1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 5, 0, 8'h77, 1'b1, 2, 0, 0, 0};
        vecs[6] = '{1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 8'h90, 8'h11, 6, 2, 8'h3C, 1'b0, 9, 1, 1, 6};
        vecs[7] = '{1'b0, 8'h64, 8'h00, 1'b1, 1'b1, 8'h91, 8'h12, 7, 0, 8'h05, 1'b1, 2, 0, 0, 0};
        vecs[8] = '{1'b1, 8'h66, 8'h55, 1'b1, 1'b1, 8'h92, 8'h13, 7, 0, 8'h55, 1'b1, 3, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_ram_req", 32'(ram_req_o), 32'd0);
        check("rst_cache_fill", 32'(cache_fill_o), 32'd0);
        check("rst_lookup", 32'(cache_lookup_o), 32'd0);
        check("rst_hit_count", 32'(hit_count_o), 32'd0);
        check("rst_miss_count", 32'(miss_count_o), 32'd0);

        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            vic_valid = v.vv; vic_dirty = v.vd; vic_tag = v.vtag; vic_data = v.vdata;
            vic_slot = v.slot;
            ram_lat = v.lat;
            rd0 = rd_cnt; wr0 = wr_cnt; rq0 = req_cyc; f0 = fill_cnt;
            wait_ready();
            drive(v.wr, v.addr, v.wdata, 1'b0, acc);
            sbq.push_back('{v.exp_data, v.exp_hit, acc, v.exp_lat});
            drain();
            @(negedge clk);
            if (v.exp_hit) exp_hits++; else exp_miss++;
            check($sformatf("v%0d_ram_reads", i), 32'(rd_cnt - rd0), 32'(v.exp_rd));
            check($sformatf("v%0d_ram_writes", i), 32'(wr_cnt - wr0), 32'(v.exp_wr));
            check($sformatf("v%0d_ram_req_cycles", i), 32'(req_cyc - rq0), 32'(v.exp_req));
            check($sformatf("v%0d_hit_count", i), 32'(hit_count_o), 32'(exp_hits));
            check($sformatf("v%0d_miss_count", i), 32'(miss_count_o), 32'(exp_miss));
            if (v.wr || !v.exp_hit) begin
                check($sformatf("v%0d_fills", i), 32'(fill_cnt - f0), 32'd1);
                check($sformatf("v%0d_fill_dirty", i), 32'(last_fill_dirty), 32'(v.wr));
                check($sformatf("v%0d_fill_data", i), 32'(last_fill_data),
                      32'(v.wr ? v.wdata : v.exp_data));
            end else
                check($sformatf("v%0d_fills", i), 32'(fill_cnt - f0), 32'd0);
            if (v.exp_wr > 0) begin
                check($sformatf("v%0d_wb_addr", i), 32'(last_wr_addr), 32'(v.vtag));
                check($sformatf("v%0d_wb_data", i), 32'(last_wr_data), 32'(v.vdata));
            end
        end

        // Reset while a refill is pending: everything drops at once, nothing completes.
        vic_valid = 1'b1; vic_dirty = 1'b0; vic_slot = 7; ram_lat = 50;
        wait_ready();
        drive(1'b0, 8'hA0, 8'h00, 1'b0, acc);
        begin
            int n = 0;
            while (!ram_req_o && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rr_refill_started", 32'(ram_req_o), 32'd1);
        repeat (2) @(negedge clk);
        f0 = fill_cnt; r0 = resp_seen;
        #1 rst = 1'b1;
        #1;
        check("rr_ram_req_drop", 32'(ram_req_o), 32'd0);
        check("rr_fill_low", 32'(cache_fill_o), 32'd0);
        check("rr_resp_low", 32'(resp_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rr_req_ready", 32'(req_ready_o), 32'd1);
        check("rr_no_fill", 32'(fill_cnt - f0), 32'd0);
        check("rr_no_resp", 32'(resp_seen - r0), 32'd0);
        check("rr_ram_req_idle", 32'(ram_req_o), 32'd0);
        check("rr_hit_count", 32'(hit_count_o), 32'd0);
        check("rr_miss_count", 32'(miss_count_o), 32'd0);

        // 256 back-to-back read hits with req_valid held high throughout.
        r0 = resp_seen; a0 = acc_cnt;
        for (int i = 0; i < 256; i++) begin
            wait_ready();
            if (i == 255) check("wrap_pre_count", 32'(hit_count_o), 32'd255);
            drive(1'b0, 8'h04, 8'h00, 1'b1, acc);
            sbq.push_back('{8'h77, 1'b1, acc, 2});
        end
        req_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        check("wrap_accepts", 32'(acc_cnt - a0), 32'd256);
        check("wrap_resps", 32'(resp_seen - r0), 32'd256);
        check("wrap_hit_count", 32'(hit_count_o), 32'd0);
        check("wrap_miss_count", 32'(miss_count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
